// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for a shared 32-bit barrel shifter.
// Optional SHIFT_ARB_ERR_EN adds out_err and zeroes results of illegal opcodes.
module shift_arbiter #(
  parameter int DW      = 32,
  parameter int SW      = 5,
  parameter int RR_INIT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic [2:0]    r0_op,
  input  logic [DW-1:0] r0_data,
  input  logic [SW-1:0] r0_shamt,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic [2:0]    r1_op,
  input  logic [DW-1:0] r1_data,
  input  logic [SW-1:0] r1_shamt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_id,
`ifdef SHIFT_ARB_ERR_EN
  output logic          out_err,
`endif
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t        state, state_nxt;
  logic          ptr;
  logic [2:0]    op_q;
  logic [DW-1:0] data_q;
  logic [SW-1:0] shamt_q;
  logic          id_q;
  logic [DW-1:0] result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ptr names the requester that wins a tie; ready is gated by reset so it reads 0 while held.
  always_comb begin
    state_nxt = state;
    r0_ready  = 1'b0;
    r1_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && r0_valid && (!r1_valid || !ptr)) begin
          r0_ready  = 1'b1;
          state_nxt = EXEC;
        end else if (rst_n && r1_valid) begin
          r1_ready  = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  // Rotates rely on DW == 2**SW: ~shamt equals DW-1-shamt, so shamt 0 contributes nothing.
  always_comb begin
    result = data_q;
    case (op_q)
      3'd0: result = data_q >> shamt_q;
      3'd1: result = data_q << shamt_q;
      3'd2: result = (data_q >> shamt_q) | ((data_q << 1) << (~shamt_q));
      3'd3: result = (data_q << shamt_q) | ((data_q >> 1) >> (~shamt_q));
      3'd4: result = DW'($signed(data_q) >>> shamt_q);
`ifdef SHIFT_ARB_ERR_EN
      default: result = '0;
`else
      default: result = data_q;
`endif
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= (RR_INIT != 0);
      op_q     <= '0;
      data_q   <= '0;
      shamt_q  <= '0;
      id_q     <= 1'b0;
      out_data <= '0;
      out_id   <= 1'b0;
    end else begin
      if (r0_ready) begin
        op_q    <= r0_op;
        data_q  <= r0_data;
        shamt_q <= r0_shamt;
        id_q    <= 1'b0;
        ptr     <= 1'b1;
      end else if (r1_ready) begin
        op_q    <= r1_op;
        data_q  <= r1_data;
        shamt_q <= r1_shamt;
        id_q    <= 1'b1;
        ptr     <= 1'b0;
      end
      if (state == EXEC) begin
        out_data <= result;
        out_id   <= id_q;
      end
    end
  end

`ifdef SHIFT_ARB_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               out_err <= 1'b0;
    else if (state == EXEC)   out_err <= (op_q > 3'd4);
  end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter; checks the out_err path when SHIFT_ARB_ERR_EN is defined.
module tb_shift_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_valid = 1'b0, r1_valid = 1'b0;
  logic        r0_ready, r1_ready;
  logic [2:0]  r0_op = '0, r1_op = '0;
  logic [31:0] r0_data = '0, r1_data = '0;
  logic [4:0]  r0_shamt = '0, r1_shamt = '0;
  logic        out_valid, out_id, busy;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
`ifdef SHIFT_ARB_ERR_EN
  logic        out_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_arbiter #(.DW(32), .SW(5), .RR_INIT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_data(r0_data), .r0_shamt(r0_shamt),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_data(r1_data), .r1_shamt(r1_shamt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
`ifdef SHIFT_ARB_ERR_EN
    .out_err(out_err),
`endif
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic drive(input bit id, input logic v, input logic [2:0] op,
                       input logic [31:0] d, input logic [4:0] s);
    if (id) begin
      r1_valid = v; r1_op = op; r1_data = d; r1_shamt = s;
    end else begin
      r0_valid = v; r0_op = op; r0_data = d; r0_shamt = s;
    end
  endtask

  // Starts at a negedge in IDLE with out_ready high; ends at the negedge back in IDLE.
  task automatic run_one(input string tag, input bit id, input logic [2:0] op,
                         input logic [31:0] d, input logic [4:0] s, input logic [31:0] exp);
    drive(id, 1'b1, op, d, s);
    #1;
    chk({tag, "_ready"}, id ? r1_ready : r0_ready, 32'd1);
    chk({tag, "_busy0"}, busy, 32'd0);
    tick;
    drive(id, 1'b0, op, d, s);
    chk({tag, "_exec_valid"}, out_valid, 32'd0);
    chk({tag, "_exec_busy"}, busy, 32'd1);
    tick;
    chk({tag, "_valid"}, out_valid, 32'd1);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_id"}, out_id, 32'(id));
`ifdef SHIFT_ARB_ERR_EN
    chk({tag, "_err"}, out_err, (op > 3'd4) ? 32'd1 : 32'd0);
`endif
    tick;
    chk({tag, "_done_valid"}, out_valid, 32'd0);
    chk({tag, "_done_busy"}, busy, 32'd0);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values, including ready held low even with a valid request present
    tick;
    r0_valid = 1'b1;
    #1;
    chk("rst_r0_ready", r0_ready, 32'd0);
    chk("rst_r1_ready", r1_ready, 32'd0);
    chk("rst_valid", out_valid, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_id", out_id, 32'd0);
    chk("rst_busy", busy, 32'd0);
`ifdef SHIFT_ARB_ERR_EN
    chk("rst_err", out_err, 32'd0);
`endif
    r0_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;

    // Both requesters always valid: grants alternate starting with r0
    drive(1'b0, 1'b1, 3'd1, 32'h0000_00F0, 5'd4);
    drive(1'b1, 1'b1, 3'd0, 32'hF000_0000, 5'd4);
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("rr_r0_ready", r0_ready, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_r1_ready", r1_ready, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick;
      tick;
      chk("rr_id", out_id, 32'(i % 2));
      chk("rr_data", out_data, (i % 2 == 0) ? 32'h0000_0F00 : 32'h0F00_0000);
      tick;
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    tick;

    run_one("lsr", 1'b0, 3'd0, 32'h8000_0000, 5'd4,  32'h0800_0000);
    run_one("asr_neg", 1'b0, 3'd4, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    run_one("asr_pos", 1'b1, 3'd4, 32'h4000_0000, 5'd4,  32'h0400_0000);
    run_one("rol", 1'b0, 3'd3, 32'h8000_0001, 5'd1,  32'h0000_0003);
    run_one("ror", 1'b1, 3'd2, 32'h0000_0001, 5'd1,  32'h8000_0000);
    run_one("ror0", 1'b0, 3'd2, 32'h1234_5678, 5'd0,  32'h1234_5678);
    run_one("rol0", 1'b1, 3'd3, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
    run_one("lsl31", 1'b0, 3'd1, 32'h0000_0003, 5'd31, 32'h8000_0000);
    run_one("lsr31", 1'b1, 3'd0, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001);

    // Result held while the consumer stalls; the waiting requester is not granted
    out_ready = 1'b0;
    drive(1'b0, 1'b1, 3'd0, 32'hA5A5_A5A5, 5'd8);
    #1;
    chk("stall_accept", r0_ready, 32'd1);
    tick;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 5'd0);
    drive(1'b1, 1'b1, 3'd1, 32'h0000_0001, 5'd31);
    tick;
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", out_valid, 32'd1);
      chk("stall_data", out_data, 32'h00A5_A5A5);
      chk("stall_id", out_id, 32'd0);
      chk("stall_busy", busy, 32'd1);
      chk("stall_r0_ready", r0_ready, 32'd0);
      chk("stall_r1_ready", r1_ready, 32'd0);
      tick;
    end
    out_ready = 1'b1;
    tick;
    chk("stall_release_valid", out_valid, 32'd0);
    chk("stall_next_grant", r1_ready, 32'd1);
    tick;
    r1_valid = 1'b0;
    tick;
    chk("stall_next_data", out_data, 32'h8000_0000);
    chk("stall_next_id", out_id, 32'd1);
    tick;

    // Reset during EXEC discards the op; r1 is served next with no r0 replay
    drive(1'b0, 1'b1, 3'd1, 32'h0000_0001, 5'd3);
    tick;
    r0_valid = 1'b0;
    chk("exec_busy", busy, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("exec_rst_busy", busy, 32'd0);
    chk("exec_rst_valid", out_valid, 32'd0);
    chk("exec_rst_data", out_data, 32'd0);
    tick;
    rst_n = 1'b1;
    run_one("post_rst_r1", 1'b1, 3'd2, 32'h0000_00FF, 5'd4, 32'hF000_000F);

    // Reset during HOLD drops out_valid immediately
    drive(1'b0, 1'b1, 3'd0, 32'hFFFF_0000, 5'd16);
    tick;
    r0_valid = 1'b0;
    tick;
    chk("hold_valid", out_valid, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("hold_rst_valid", out_valid, 32'd0);
    chk("hold_rst_id", out_id, 32'd0);
    tick;
    rst_n = 1'b1;
    tick;

    // Fresh pointer after reset: r0 wins a tie again
    drive(1'b0, 1'b1, 3'd0, 32'h10, 5'd4);
    drive(1'b1, 1'b1, 3'd0, 32'h20, 5'd4);
    #1;
    chk("rr_after_rst_r0", r0_ready, 32'd1);
    chk("rr_after_rst_r1", r1_ready, 32'd0);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    tick;

    // Illegal opcodes
`ifdef SHIFT_ARB_ERR_EN
    run_one("ill5", 1'b0, 3'd5, 32'h0000_1234, 5'd3, 32'h0000_0000);
    run_one("ill7", 1'b1, 3'd7, 32'hCAFE_F00D, 5'd0, 32'h0000_0000);
    run_one("legal_after_ill", 1'b0, 3'd0, 32'h0000_1234, 5'd4, 32'h0000_0123);
`else
    run_one("ill5", 1'b0, 3'd5, 32'h0000_1234, 5'd3, 32'h0000_1234);
    run_one("ill7", 1'b1, 3'd7, 32'hCAFE_F00D, 5'd9, 32'hCAFE_F00D);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
